// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: two-stage pipelined multiplier built on the vertical-and-crosswise
// decomposition. Stage 1 takes operand magnitudes and forms the four half products.
// Stage 2 aligns and sums the half products, then restores the sign.
// Both stages use a valid/ready handshake and sustain one product per cycle under backpressure.
module vedic_mult_pipe #(
   parameter int WIDTH = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               out_norm
);

   localparam int H  = WIDTH / 2;
   localparam int PW = 2 * WIDTH;

   logic            s1_en;
   logic            s2_en;
   logic [WIDTH-1:0] ma_s;
   logic [WIDTH-1:0] mb_s;
   logic [2*H:0]    mid_s;
   logic [PW-1:0]   mag_s;

   logic            s1_valid_d, s1_valid_q;
   logic [2*H-1:0]  ll_d, ll_q;
   logic [2*H-1:0]  hl_d, hl_q;
   logic [2*H-1:0]  lh_d, lh_q;
   logic [2*H-1:0]  hh_d, hh_q;
   logic            neg_d, neg_q;
   logic            sgn_d, sgn_q;
   logic            out_valid_d, out_valid_q;
   logic [PW-1:0]   product_d, product_q;
   logic            norm_d, norm_q;

   // Pipeline advance enables. A stage moves when its downstream slot is free or draining.
   always_comb begin
      s2_en = !out_valid_q | out_ready;
      s1_en = !s1_valid_q | s2_en;
   end

   assign in_ready  = s1_en;
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign out_norm  = norm_q;

   // Stage 1: form the operand magnitudes (the most negative value maps to 2^(W-1)) and the four half products.
   always_comb begin
      ma_s = (in_signed & a[WIDTH-1]) ? -a : a;
      mb_s = (in_signed & b[WIDTH-1]) ? -b : b;
      if (s1_en) begin
         s1_valid_d = in_valid;
         ll_d  = {{H{1'b0}}, ma_s[H-1:0]}     * {{H{1'b0}}, mb_s[H-1:0]};
         hl_d  = {{H{1'b0}}, ma_s[WIDTH-1:H]} * {{H{1'b0}}, mb_s[H-1:0]};
         lh_d  = {{H{1'b0}}, ma_s[H-1:0]}     * {{H{1'b0}}, mb_s[WIDTH-1:H]};
         hh_d  = {{H{1'b0}}, ma_s[WIDTH-1:H]} * {{H{1'b0}}, mb_s[WIDTH-1:H]};
         neg_d = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
         sgn_d = in_signed;
      end else begin
         s1_valid_d = s1_valid_q;
         ll_d  = ll_q;
         hl_d  = hl_q;
         lh_d  = lh_q;
         hh_d  = hh_q;
         neg_d = neg_q;
         sgn_d = sgn_q;
      end
   end

   // Stage 2: crosswise sum with a carry bit, place the halves, then restore the sign.
   always_comb begin
      mid_s = {1'b0, hl_q} + {1'b0, lh_q};
      mag_s = {{WIDTH{1'b0}}, ll_q}
            + ({{(WIDTH-1){1'b0}}, mid_s} << H)
            + {hh_q, {WIDTH{1'b0}}};
      if (s2_en) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            product_d = neg_q ? -mag_s : mag_s;
            norm_d    = !sgn_q & mag_s[PW-1];
         end else begin
            product_d = product_q;
            norm_d    = norm_q;
         end
      end else begin
         out_valid_d = out_valid_q;
         product_d   = product_q;
         norm_d      = norm_q;
      end
   end

   // Pipeline registers. Reset drops any in-flight transaction and clears the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         ll_q        <= '0;
         hl_q        <= '0;
         lh_q        <= '0;
         hh_q        <= '0;
         neg_q       <= 1'b0;
         sgn_q       <= 1'b0;
         out_valid_q <= 1'b0;
         product_q   <= '0;
         norm_q      <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         ll_q        <= ll_d;
         hl_q        <= hl_d;
         lh_q        <= lh_d;
         hh_q        <= hh_d;
         neg_q       <= neg_d;
         sgn_q       <= sgn_d;
         out_valid_q <= out_valid_d;
         product_q   <= product_d;
         norm_q      <= norm_d;
      end
   end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb_vedic_mult_pipe: directed and randomised checks of vedic_mult_pipe at WIDTH=8 and WIDTH=24.
module tb_vedic_mult_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic        v8, s8, or8, ir8, ov8, n8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   logic        v24, s24, or24, ir24, ov24, n24;
   logic [23:0] a24, b24;
   logic [47:0] p24;

   int n_vec = 0;
   int n_err = 0;

   vedic_mult_pipe #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8),
      .in_signed(s8), .out_valid(ov8), .out_ready(or8), .product(p8), .out_norm(n8)
   );

   vedic_mult_pipe #(.WIDTH(24)) u_dut24 (
      .clk(clk), .rst_n(rst_n), .in_valid(v24), .in_ready(ir24), .a(a24), .b(b24),
      .in_signed(s24), .out_valid(ov24), .out_ready(or24), .product(p24), .out_norm(n24)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit w, input logic v, input logic [23:0] a, input logic [23:0] b,
                        input logic s, input logic ordy);
      if (w) begin
         v24 = v; a24 = a; b24 = b; s24 = s; or24 = ordy;
      end else begin
         v8 = v; a8 = a[7:0]; b8 = b[7:0]; s8 = s; or8 = ordy;
      end
   endtask

   // pn packs {out_norm, product}
   task automatic sample(input bit w, output logic ir, output logic ov, output logic [63:0] pn);
      if (w) begin
         ir = ir24; ov = ov24; pn = {15'd0, n24, p24};
      end else begin
         ir = ir8; ov = ov8; pn = {47'd0, n8, p8};
      end
   endtask

   // Independent reference: sign-extend to 64 bits, multiply, truncate to 2w bits.
   function automatic logic [63:0] ref_pn(input int w, input logic [23:0] a, input logic [23:0] b,
                                          input logic s);
      logic signed [63:0] sa, sb;
      logic [63:0] p, m;
      m = (64'd1 << (2 * w)) - 64'd1;
      if (s) begin
         sa = $signed({40'd0, a} << (64 - w));
         sa = sa >>> (64 - w);
         sb = $signed({40'd0, b} << (64 - w));
         sb = sb >>> (64 - w);
         p  = sa * sb;
      end else begin
         p = {40'd0, a} * {40'd0, b};
      end
      p = p & m;
      return p | ((!s && p[2 * w - 1]) ? (64'd1 << (2 * w)) : 64'd0);
   endfunction

   task automatic run_vec(input bit w, input logic [23:0] a, input logic [23:0] b, input logic s,
                          input logic [47:0] ep, input logic en, input string tag);
      logic ir, ov;
      logic [63:0] pn, exp;
      exp = w ? {15'd0, en, ep} : {47'd0, en, ep[15:0]};
      @(negedge clk);
      drive(w, 1'b1, a, b, s, 1'b1);
      #1 sample(w, ir, ov, pn);
      check_val({tag, "_ready"}, {63'd0, ir}, 64'd1);
      @(negedge clk);
      drive(w, 1'b0, 24'd0, 24'd0, 1'b0, 1'b1);
      #1 sample(w, ir, ov, pn);
      check_val({tag, "_early"}, {63'd0, ov}, 64'd0);
      @(negedge clk);
      #1 sample(w, ir, ov, pn);
      check_val({tag, "_valid"}, {63'd0, ov}, 64'd1);
      check_val({tag, "_prod"}, pn, exp);
   endtask

   task automatic rnd_run(input bit w, input int n);
      int acc, cyc, wd;
      logic [63:0] q[$];
      logic pend, cv, cs, ordy, ir, ov;
      logic [23:0] ca, cb, mask;
      logic [63:0] pn, exp;
      wd = w ? 24 : 8;
      mask = w ? 24'hFFFFFF : 24'h0000FF;
      acc = 0; cyc = 0; pend = 1'b0;
      cv = 1'b0; cs = 1'b0; ca = 24'd0; cb = 24'd0;
      while (acc < n && cyc < 8 * n) begin
         @(negedge clk);
         cyc++;
         if (!pend) begin
            cv = ($urandom_range(0, 3) != 0);
            ca = $urandom & mask;
            cb = $urandom & mask;
            cs = $urandom_range(0, 1) != 0;
         end
         ordy = ($urandom_range(0, 3) != 0);
         drive(w, cv, ca, cb, cs, ordy);
         #1 sample(w, ir, ov, pn);
         if (ov && ordy) begin
            exp = (q.size() != 0) ? q.pop_front() : 64'hDEAD_0000_0000_0000;
            check_val(w ? "rnd24" : "rnd8", pn, exp);
         end
         if (cv && ir) begin
            q.push_back(ref_pn(wd, ca, cb, cs));
            acc++;
         end
         pend = cv && !ir;
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(w, 1'b0, 24'd0, 24'd0, 1'b0, 1'b1);
         #1 sample(w, ir, ov, pn);
         if (ov) begin
            exp = (q.size() != 0) ? q.pop_front() : 64'hDEAD_0000_0000_0000;
            check_val(w ? "rnd24_drain" : "rnd8_drain", pn, exp);
         end
      end
      check_val("rnd_left", 64'(q.size()), 64'd0);
      check_val("rnd_count", 64'(acc), 64'(n));
   endtask

   initial begin
      logic ir, ov;
      logic [63:0] pn;
      drive(1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 24'd0, 24'd0, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         #1 sample(w[0], ir, ov, pn);
         check_val("rst_ov", {63'd0, ov}, 64'd0);
         check_val("rst_ir", {63'd0, ir}, 64'd1);
         check_val("rst_prod", pn, 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // WIDTH=24 directed
      run_vec(1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, 1'b1, "u24_max");
      run_vec(1'b1, 24'h800000, 24'h800000, 1'b0, 48'h400000000000, 1'b0, "u24_one");
      run_vec(1'b1, 24'hC00000, 24'hC00000, 1'b0, 48'h900000000000, 1'b1, "u24_1p5");
      run_vec(1'b1, 24'hFFFFFF, 24'h000001, 1'b1, 48'hFFFFFFFFFFFF, 1'b0, "s24_m1");

      // WIDTH=8 directed
      run_vec(1'b0, 24'h80, 24'h80, 1'b1, 48'h4000, 1'b0, "s8_minmin");
      run_vec(1'b0, 24'hFD, 24'h05, 1'b1, 48'hFFF1, 1'b0, "s8_m3x5");
      run_vec(1'b0, 24'h7F, 24'h80, 1'b1, 48'hC080, 1'b0, "s8_maxmin");
      run_vec(1'b0, 24'h00, 24'hFF, 1'b1, 48'h0000, 1'b0, "s8_zero");
      run_vec(1'b0, 24'hFF, 24'hFF, 1'b0, 48'hFE01, 1'b1, "u8_max");

      // WIDTH=8 backpressure
      @(negedge clk);
      drive(1'b0, 1'b1, 24'd3, 24'd4, 1'b0, 1'b0);
      #1 sample(1'b0, ir, ov, pn);
      check_val("bp_ir0", {63'd0, ir}, 64'd1);
      @(negedge clk);
      drive(1'b0, 1'b1, 24'hFD, 24'h05, 1'b1, 1'b0);
      #1 sample(1'b0, ir, ov, pn);
      check_val("bp_ir1", {63'd0, ir}, 64'd1);
      @(negedge clk);
      drive(1'b0, 1'b1, 24'd200, 24'd100, 1'b0, 1'b0);
      #1 sample(1'b0, ir, ov, pn);
      check_val("bp_ir2", {63'd0, ir}, 64'd0);
      check_val("bp_ov2", {63'd0, ov}, 64'd1);
      check_val("bp_p2", pn, 64'h000C);
      @(negedge clk);
      #1 sample(1'b0, ir, ov, pn);
      check_val("bp_ir3", {63'd0, ir}, 64'd0);
      check_val("bp_hold", pn, 64'h000C);
      drive(1'b0, 1'b1, 24'd200, 24'd100, 1'b0, 1'b1);
      #1 sample(1'b0, ir, ov, pn);
      check_val("bp_ir_rel", {63'd0, ir}, 64'd1);
      @(negedge clk);
      drive(1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 1'b1);
      #1 sample(1'b0, ir, ov, pn);
      check_val("bp_ov_b", {63'd0, ov}, 64'd1);
      check_val("bp_p_b", pn, 64'hFFF1);
      @(negedge clk);
      #1 sample(1'b0, ir, ov, pn);
      check_val("bp_ov_c", {63'd0, ov}, 64'd1);
      check_val("bp_p_c", pn, 64'h4E20);
      @(negedge clk);
      #1 sample(1'b0, ir, ov, pn);
      check_val("bp_empty", {63'd0, ov}, 64'd0);

      // randomised traffic
      rnd_run(1'b0, 5000);
      rnd_run(1'b1, 5000);

      // reset with both stages full
      @(negedge clk);
      drive(1'b0, 1'b1, 24'd9, 24'd9, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b1, 24'd7, 24'd7, 1'b0, 1'b0);
      @(negedge clk);
      #1 sample(1'b0, ir, ov, pn);
      check_val("mid_full_ir", {63'd0, ir}, 64'd0);
      rst_n = 1'b0;
      #1 sample(1'b0, ir, ov, pn);
      check_val("mid_rst_ov", {63'd0, ov}, 64'd0);
      check_val("mid_rst_ir", {63'd0, ir}, 64'd1);
      drive(1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(1'b0, 24'h7F, 24'h7F, 1'b0, 48'h3F01, 1'b0, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
